// File: rtl/config_pkg.sv
// Shared definitions for the configuration chain loader: FSM state encoding
// and the CRC-16-CCITT constants used when CONFIG_LOADER_CRC_EN is defined.
package config_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } loader_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/config_crc16.sv
// Serial CRC-16-CCITT (MSB-first, no reflection, no final XOR).
// clear reloads the init value; en folds din into the running remainder.
module config_crc16
  import config_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  // Next remainder: shift left, XOR the polynomial when the feedback bit is set.
  always_comb begin
    fb    = crc_q[15] ^ din;
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  // Remainder register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) crc_q <= CRC16_INIT;
    else         crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/config_chain_loader.sv
// Configuration chain loader: takes bitstream words over a valid/ready stream
// and shifts exactly CHAIN_LENGTH bits MSB-first onto cfg_data, one bit per
// cfg_enable cycle. Optional CRC check word enabled by CONFIG_LOADER_CRC_EN.
// Handshake: a word transfers on a rising edge where word_valid and word_ready
// are both high; word_ready depends only on state, never on word_valid.
module config_chain_loader
  import config_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 146
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  cfg_enable,
  output logic                  cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  localparam int CNT_WIDTH = $clog2(CHAIN_LENGTH + 1);
  localparam int WB_WIDTH  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BIT  = CNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [WB_WIDTH-1:0]  LAST_WBIT = WB_WIDTH'(WORD_WIDTH - 1);

  loader_state_e         state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_WIDTH-1:0]   wbit_q, wbit_d;
  logic                  crc_clear;

`ifdef CONFIG_LOADER_CRC_EN
  logic        error_q, error_d;
  logic [15:0] crc_val;

  config_crc16 u_crc (
    .clock  (clock),
    .nreset (nreset),
    .clear  (crc_clear),
    .en     (cfg_enable),
    .din    (cfg_data),
    .crc    (crc_val)
  );
`endif

  // Next-state logic: counters, word register and state transitions.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    bit_cnt_d = bit_cnt_q;
    wbit_d    = wbit_q;
    crc_clear = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
    error_d   = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          wbit_d    = '0;
          crc_clear = 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
          error_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (word_valid) begin
          word_d  = word_data;
          wbit_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        word_d    = word_q << 1;
        bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
        wbit_d    = wbit_q + WB_WIDTH'(1);
        // Chain completion wins over word exhaustion: the last word's tail is dropped.
        if (bit_cnt_q == LAST_BIT) begin
`ifdef CONFIG_LOADER_CRC_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else if (wbit_q == LAST_WBIT) begin
          state_d = LOAD;
        end
      end
`ifdef CONFIG_LOADER_CRC_EN
      CHECK: begin
        if (word_valid) begin
          error_d = (word_data[15:0] != crc_val);
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset aborts any load in progress.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      bit_cnt_q <= '0;
      wbit_q    <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      wbit_q    <= wbit_d;
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  // Sticky CRC error flag, cleared by an accepted start.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) error_q <= 1'b0;
    else         error_q <= error_d;
  end
  assign error      = error_q;
  assign word_ready = (state_q == LOAD) || (state_q == CHECK);
  assign busy       = (state_q == LOAD) || (state_q == SHIFT) || (state_q == CHECK);
`else
  assign error      = 1'b0;
  assign word_ready = (state_q == LOAD);
  assign busy       = (state_q == LOAD) || (state_q == SHIFT);
`endif

  // Outputs decode from state so reset forces them low immediately.
  assign cfg_enable = (state_q == SHIFT);
  assign cfg_data   = (state_q == SHIFT) && word_q[WORD_WIDTH-1];
  assign done       = (state_q == DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader with a 146-bit chain model.
// Honors CONFIG_LOADER_CRC_EN to send the check word and expect the error flag.
module tb_config_chain_loader;
  import config_pkg::*;

  localparam int W = 32;
  localparam int L = 146;

  logic         clock = 1'b0;
  logic         nreset;
  logic         start;
  logic         word_valid;
  logic [W-1:0] word_data;
  logic         word_ready, cfg_enable, cfg_data, busy, done, error;
  logic [2:0]   dbg_state;

  logic [L-1:0] chain;
  logic [L-1:0] exp_chain;
  logic [0:0]   exp_q[$];
  logic [W-1:0] ws[5];
  logic [15:0]  model_crc;
  logic         exp_error;
  int           checks = 0;
  int           errors = 0;
  int           enable_cnt = 0;
  int           done_cnt = 0;
  int           exp_pos = 0;

  config_chain_loader #(.WORD_WIDTH(W), .CHAIN_LENGTH(L)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .cfg_enable (cfg_enable),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // Clock.
  always #5 clock = ~clock;

  // Chain model: one shift per enabled cycle, keeps contents across reset.
  always @(posedge clock) begin
    if (cfg_enable) chain <= {chain[L-2:0], cfg_data};
  end

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: pop one expected bit per enabled cycle, count done pulses.
  always @(negedge clock) begin
    if (nreset) begin
      if (cfg_enable) begin
        enable_cnt++;
        if (exp_q.size() == 0) check("cfg_extra_bit", 1, 0);
        else check("cfg_data", cfg_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Push the bits of a word that will actually reach the chain.
  task automatic push_word(input logic [W-1:0] w);
    int nbits;
    logic b;
    nbits = L - exp_pos;
    if (nbits > W) nbits = W;
    for (int i = 0; i < nbits; i++) begin
      b = w[W-1-i];
      exp_q.push_back(b);
      exp_chain[L-1-exp_pos] = b;
      model_crc = crc_step(model_crc, b);
      exp_pos++;
    end
  endtask

  task automatic drive_word(input logic [W-1:0] w, input int gap);
    bit accepted;
    accepted = 0;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    word_valid = 1'b1;
    word_data  = w;
    for (int c = 0; c < 300; c++) begin
      if (word_ready) begin
        @(posedge clock);
        accepted = 1;
        break;
      end
      @(negedge clock);
    end
    if (!accepted) check("word_handshake_timeout", 0, 1);
    #1;
    word_valid = 1'b0;
  endtask

  task automatic begin_load();
    enable_cnt = 0;
    done_cnt   = 0;
    exp_pos    = 0;
    model_crc  = 16'hFFFF;
    exp_q.delete();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared_by_start", error, 0);
    check("state_load", dbg_state, LOAD);
  endtask

  task automatic run_load(input int gap, input bit poke_start, input bit flip);
    bit seen;
    begin_load();
    for (int k = 0; k < 5; k++) begin
      push_word(ws[k]);
      drive_word(ws[k], gap);
      if (k == 0 && poke_start) begin
        @(negedge clock);
        check("state_shift_at_poke", dbg_state, SHIFT);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    end
`ifdef CONFIG_LOADER_CRC_EN
    drive_word({16'hA5A5, model_crc ^ {15'b0, flip}}, gap);
    exp_error = flip;
`else
    exp_error = 1'b0;
`endif
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      check("busy_in_done", busy, 0);
      check("ready_in_done", word_ready, 0);
      check("error_in_done", error, exp_error);
      check("enable_count", enable_cnt, L);
      check("queue_drained", exp_q.size(), 0);
      check("chain_contents", chain, exp_chain);
      @(negedge clock);
      #1;
      check("done_one_cycle", done, 0);
      check("done_pulse_count", done_cnt, 1);
      check("state_idle_after", dbg_state, IDLE);
      check("error_sticky", error, exp_error);
    end
  endtask

  task automatic rand_words();
    for (int k = 0; k < 5; k++) ws[k] = $urandom();
  endtask

  initial begin
    logic [L-1:0] one_hot;
    nreset     = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    chain      = '0;
    exp_chain  = '0;
    #1;
    check("rst_ready", word_ready, 0);
    check("rst_enable", cfg_enable, 0);
    check("rst_data", cfg_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_state", dbg_state, IDLE);
    repeat (3) @(negedge clock);
    nreset = 1'b1;

    // Nominal back-to-back load.
    rand_words();
    run_load(0, 0, 0);

    // Ordering: only the very first bit set.
    ws[0] = 32'h8000_0000;
    for (int k = 1; k < 5; k++) ws[k] = '0;
    run_load(0, 0, 0);
    one_hot = '0;
    one_hot[L-1] = 1'b1;
    check("ordering_chain", chain, one_hot);

    // Backpressure: 7 idle cycles before each word.
    rand_words();
    run_load(7, 0, 0);

    // Reset after 70 shifts.
    rand_words();
    begin_load();
    for (int k = 0; k < 3; k++) begin
      push_word(ws[k]);
      drive_word(ws[k], 0);
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      #2;
      if (enable_cnt >= 70) break;
    end
    check("shifts_before_reset", enable_cnt, 70);
    nreset = 1'b0;
    #1;
    check("abort_enable", cfg_enable, 0);
    check("abort_data", cfg_data, 0);
    check("abort_ready", word_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_state", dbg_state, IDLE);
    exp_q.delete();
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    rand_words();
    run_load(1, 0, 0);

    // start pulsed while shifting is ignored.
    rand_words();
    run_load(2, 1, 0);

    // Corrupted check word, then a clean load that must clear the flag.
    rand_words();
    run_load(0, 0, 1);
    rand_words();
    run_load(3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
